// File: rtl/timer_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizes for the timer and its capture reader.
// No logic, declarations only.
// Not applicable: no flow control here.
package timer_pkg;

    localparam int DEF_TIMER_BITWIDTH = 32;
    localparam int DEF_NB_CAPTURES    = 10;
    localparam int DEF_CH_W           = $clog2(DEF_NB_CAPTURES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EMIT   = 3'd2,
        CLEAR  = 3'd3,
        GUARD  = 3'd4
    } reader_state_e;

    typedef struct packed {
        logic [DEF_CH_W-1:0]           channel;
        logic [DEF_TIMER_BITWIDTH-1:0] time_val;
        logic [DEF_TIMER_BITWIDTH-1:0] delta;
        logic                          first;
    } capture_evt_t;

endpackage

// File: rtl/capture_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin pick of the first set request at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
module capture_rr_arbiter #(
    parameter  int NB = 10,
    localparam int IW = $clog2(NB)
) (
    input  logic [NB-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    int idx;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = NB - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NB;
            if (req[idx]) begin
                grant_idx   = IW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_capture_reader.sv
`timescale 1ns/1ps
// Drains timer capture flags round-robin into a valid/ready event stream with per-channel delta.
// Latency: flag seen in IDLE -> event valid two edges later; >=5 cycles per event.
// Backpressure: event fields held while valid && !ready; re-arm pulse only after handshake.
module timer_capture_reader
    import timer_pkg::*;
#(
    parameter  int TIMER_BITWIDTH = DEF_TIMER_BITWIDTH,
    parameter  int NB_CAPTURES    = DEF_NB_CAPTURES,
    localparam int CH_W           = $clog2(NB_CAPTURES)
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  enable_in,
    input  logic [NB_CAPTURES-1:0]                captured_in,
    input  logic [NB_CAPTURES*TIMER_BITWIDTH-1:0] counter_in,
    output logic [NB_CAPTURES-1:0]                rst_capture_out,
    output logic                                  evt_valid_out,
    input  logic                                  evt_ready_in,
    output logic [CH_W-1:0]                       evt_channel_out,
    output logic [TIMER_BITWIDTH-1:0]             evt_time_out,
    output logic [TIMER_BITWIDTH-1:0]             evt_delta_out,
    output logic                                  evt_first_out,
    output logic                                  busy_out
);

    reader_state_e state, state_nxt;

    logic [CH_W-1:0]                             chan;
    logic [CH_W-1:0]                             rr_ptr;
    logic [NB_CAPTURES-1:0]                      seen;
    logic [NB_CAPTURES-1:0][TIMER_BITWIDTH-1:0]  last_time;
    logic [CH_W-1:0]                             grant_idx;
    logic                                        grant_valid;
    logic                                        take;
    logic                                        hs;
    logic [TIMER_BITWIDTH-1:0]                   sel_time;

    capture_rr_arbiter #(.NB(NB_CAPTURES)) u_arb (
        .req         (captured_in),
        .ptr         (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign take     = (state == IDLE) && enable_in && grant_valid;
    assign hs       = (state == EMIT) && evt_valid_out && evt_ready_in;
    assign sel_time = counter_in[int'(chan)*TIMER_BITWIDTH +: TIMER_BITWIDTH];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SELECT;
            SELECT:  state_nxt = EMIT;
            EMIT:    if (hs) state_nxt = CLEAR;
            CLEAR:   state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            chan            <= '0;
            rr_ptr          <= '0;
            seen            <= '0;
            last_time       <= '0;
            rst_capture_out <= '0;
            evt_valid_out   <= 1'b0;
            evt_channel_out <= '0;
            evt_time_out    <= '0;
            evt_delta_out   <= '0;
            evt_first_out   <= 1'b0;
        end else begin
            rst_capture_out <= '0;
            if (take) chan <= grant_idx;
            if (state == SELECT) begin
                evt_valid_out   <= 1'b1;
                evt_channel_out <= chan;
                evt_time_out    <= sel_time;
                evt_delta_out   <= seen[chan] ? sel_time - last_time[chan] : '0;
                evt_first_out   <= !seen[chan];
            end
            // Commit per-channel history only once downstream has the event.
            if (hs) begin
                evt_valid_out         <= 1'b0;
                last_time[chan]       <= evt_time_out;
                seen[chan]            <= 1'b1;
                rst_capture_out[chan] <= 1'b1;
                rr_ptr                <= (chan == CH_W'(NB_CAPTURES - 1)) ? '0 : chan + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer_capture_reader.sv
`timescale 1ns/1ps
// Directed bench for timer_capture_reader with a scoreboard of expected events.
module tb_timer_capture_reader;
    import timer_pkg::*;

    localparam int W  = DEF_TIMER_BITWIDTH;
    localparam int NB = DEF_NB_CAPTURES;
    localparam int CW = $clog2(NB);

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              enable_in;
    logic [NB-1:0]     captured_in;
    logic [NB*W-1:0]   counter_in;
    logic [NB-1:0]     rst_capture_out;
    logic              evt_valid_out;
    logic              evt_ready_in;
    logic [CW-1:0]     evt_channel_out;
    logic [W-1:0]      evt_time_out;
    logic [W-1:0]      evt_delta_out;
    logic              evt_first_out;
    logic              busy_out;

    capture_evt_t           sb[$];
    logic [NB-1:0]          seen_m;
    logic [NB-1:0][W-1:0]   last_m;
    int                     checks;
    int                     errors;
    int                     lat;

    always #5 clk_in = ~clk_in;

    timer_capture_reader dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .captured_in     (captured_in),
        .counter_in      (counter_in),
        .rst_capture_out (rst_capture_out),
        .evt_valid_out   (evt_valid_out),
        .evt_ready_in    (evt_ready_in),
        .evt_channel_out (evt_channel_out),
        .evt_time_out    (evt_time_out),
        .evt_delta_out   (evt_delta_out),
        .evt_first_out   (evt_first_out),
        .busy_out        (busy_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        seen_m = '0;
        last_m = '0;
        sb.delete();
    endtask

    // Timer side: set a channel's flag and value, and record what the reader should report.
    task automatic raise(input int ch, input logic [W-1:0] v);
        capture_evt_t e;
        captured_in[ch]       = 1'b1;
        counter_in[ch*W +: W] = v;
        e.channel  = CW'(ch);
        e.time_val = v;
        e.first    = !seen_m[ch];
        e.delta    = seen_m[ch] ? v - last_m[ch] : '0;
        seen_m[ch] = 1'b1;
        last_m[ch] = v;
        sb.push_back(e);
    endtask

    task automatic check_fields(input string tag, input capture_evt_t e);
        chk({tag, "_valid"}, 64'(evt_valid_out), 64'(1'b1));
        chk({tag, "_chan"},  64'(evt_channel_out), 64'(e.channel));
        chk({tag, "_time"},  64'(evt_time_out), 64'(e.time_val));
        chk({tag, "_delta"}, 64'(evt_delta_out), 64'(e.delta));
        chk({tag, "_first"}, 64'(evt_first_out), 64'(e.first));
    endtask

    task automatic expect_event(input string tag, input int hold, output int latency);
        capture_evt_t e;
        int ch;
        latency = 0;
        while (!evt_valid_out && latency < 40) begin
            @(negedge clk_in);
            latency++;
        end
        chk({tag, "_arrived"}, 64'(evt_valid_out), 64'(1'b1));
        if (!evt_valid_out) return;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_sb: observed event ch %0d, expected none", tag, evt_channel_out);
            return;
        end
        e  = sb.pop_front();
        ch = int'(e.channel);
        for (int i = 0; i < hold; i++) begin
            check_fields({tag, "_hold"}, e);
            chk({tag, "_hold_rearm"}, 64'(rst_capture_out), 64'(0));
            @(negedge clk_in);
        end
        check_fields(tag, e);
        chk({tag, "_busy"}, 64'(busy_out), 64'(1'b1));
        evt_ready_in = 1'b1;
        @(negedge clk_in);
        evt_ready_in = 1'b0;
        chk({tag, "_valid_drop"}, 64'(evt_valid_out), 64'(1'b0));
        chk({tag, "_rearm"}, 64'(rst_capture_out), 64'(NB'(1) << ch));
        captured_in[ch] = 1'b0;
        @(negedge clk_in);
        chk({tag, "_rearm_end"}, 64'(rst_capture_out), 64'(0));
        @(negedge clk_in);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n_in     = 1'b0;
        enable_in    = 1'b1;
        captured_in  = '0;
        counter_in   = '0;
        evt_ready_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("rst_valid", 64'(evt_valid_out), 64'(0));
        chk("rst_rearm", 64'(rst_capture_out), 64'(0));
        chk("rst_busy",  64'(busy_out), 64'(0));
        chk("rst_chan",  64'(evt_channel_out), 64'(0));
        chk("rst_time",  64'(evt_time_out), 64'(0));
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Single event with latency check
        raise(3, 32'h0000_1000);
        expect_event("single", 0, lat);
        chk("single_latency", 64'(lat), 64'(2));

        // Delta across counter wrap
        raise(0, 32'hFFFF_FFF0);
        expect_event("wrap_a", 0, lat);
        raise(0, 32'h0000_0010);
        expect_event("wrap_b", 0, lat);

        // Round-robin from a fresh pointer
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        @(negedge clk_in);
        raise(1, 32'h0000_0111);
        raise(5, 32'h0000_0555);
        raise(9, 32'h0000_0999);
        expect_event("rr_1", 0, lat);
        expect_event("rr_5", 0, lat);
        expect_event("rr_9", 0, lat);
        raise(1, 32'h0000_1111);
        raise(5, 32'h0000_2555);
        expect_event("rr2_1", 0, lat);
        expect_event("rr2_5", 0, lat);

        // Backpressure for 20 cycles, then exactly one handshake
        raise(2, 32'hDEAD_BEEF);
        expect_event("bp", 20, lat);
        for (int i = 0; i < 6; i++) begin
            chk("bp_no_repeat", 64'(evt_valid_out), 64'(0));
            @(negedge clk_in);
        end
        chk("bp_sb_drained", 64'(sb.size()), 64'(0));

        // Enable low blocks new reads
        enable_in = 1'b0;
        raise(4, 32'h0000_4444);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            chk("en_off_valid", 64'(evt_valid_out), 64'(0));
            chk("en_off_busy",  64'(busy_out), 64'(0));
        end
        enable_in = 1'b1;
        expect_event("en_on", 0, lat);

        // Reset while an event is waiting in EMIT
        raise(6, 32'h0000_6666);
        lat = 0;
        while (!evt_valid_out && lat < 40) begin
            @(negedge clk_in);
            lat++;
        end
        chk("rstemit_arrived", 64'(evt_valid_out), 64'(1'b1));
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("rstemit_valid", 64'(evt_valid_out), 64'(0));
        chk("rstemit_rearm", 64'(rst_capture_out), 64'(0));
        chk("rstemit_busy",  64'(busy_out), 64'(0));
        rst_n_in = 1'b1;
        model_reset();
        chk("rstemit_rearm2", 64'(rst_capture_out), 64'(0));
        raise(6, 32'h0000_6666);
        expect_event("rstemit_reread", 0, lat);
        chk("final_sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
